rpn_keypad_ctrl: RTL

//  Scans a 4x5 key matrix, debounces, encodes the pressed key to the 5-bit RPN key code,
//  and drives the stack's in_num/intro inputs. Sits between board keypad pins and rpn_stack.

---
 rtl/rpn_pkg.sv | 36 +++
 rtl/rpn_keypad_ctrl_if.sv | 29 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/rpn_keypad_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator front end: key codes,
// digit encoding and the keypad debounce state machine states.
package rpn_pkg;

    typedef logic [4:0] key_code_t;

    // Operator and control key codes. Digits occupy 5'b0_0000..5'b0_1001.
    localparam key_code_t KEY_PLUS  = 5'b10000;
    localparam key_code_t KEY_MINUS = 5'b10001;
    localparam key_code_t KEY_BACKS = 5'b10010;
    localparam key_code_t KEY_ENTER = 5'b10011;
    localparam key_code_t KEY_UP    = 5'b10100;
    localparam key_code_t KEY_DOWN  = 5'b10101;
    localparam key_code_t KEY_NOP   = 5'b10110;

    // Debounce state machine states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    // Classification of one complete four-row scan.
    typedef enum logic [1:0] {
        FRAME_NONE   = 2'd0,
        FRAME_SINGLE = 2'd1,
        FRAME_MULTI  = 2'd2
    } frame_kind_e;

    // Digits are encoded as a zero-extended BCD value.
    function automatic key_code_t digitCode(input logic [3:0] bcd);
        return {1'b0, bcd};
    endfunction

endpackage

// File: rtl/rpn_keypad_ctrl_if.sv
// Keypad pins plus the key code / press level handed to the RPN stack.
interface rpn_keypad_ctrl_if;
    import rpn_pkg::*;

    logic [4:0] col_n;
    logic [3:0] row_n;
    key_code_t  key_code;
    logic       key_valid;
    logic       multi_key;

    // The controller drives rows and the stack-side outputs.
    modport master (
        input  col_n,
        output row_n,
        output key_code,
        output key_valid,
        output multi_key
    );

    // The board/stack side drives columns and observes the rest.
    modport slave (
        output col_n,
        input  row_n,
        input  key_code,
        input  key_valid,
        input  multi_key
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
module sync_2ff #(
    parameter int              WIDTH     = 5,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // Two back-to-back flops give the first stage time to settle from metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_q <= RESET_VAL;
            stage2_q <= RESET_VAL;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/rpn_keypad_ctrl.sv
// Scans the 4x5 key matrix, debounces whole-frame results and presents one
// stable press level plus key code to the RPN stack.
module rpn_keypad_ctrl
    import rpn_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               rst,
    rpn_keypad_ctrl_if.master  kp
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_SCANS);

    // Key-map ROM: row 3 only carries the '0' key, the rest are NOP.
    function automatic key_code_t keyMap(input logic [1:0] row, input logic [2:0] col);
        key_code_t code;
        code = KEY_NOP;
        case (row)
            2'd0: case (col)
                3'd0: code = digitCode(4'd7);
                3'd1: code = digitCode(4'd8);
                3'd2: code = digitCode(4'd9);
                3'd3: code = KEY_PLUS;
                3'd4: code = KEY_BACKS;
                default: code = KEY_NOP;
            endcase
            2'd1: case (col)
                3'd0: code = digitCode(4'd4);
                3'd1: code = digitCode(4'd5);
                3'd2: code = digitCode(4'd6);
                3'd3: code = KEY_MINUS;
                3'd4: code = KEY_ENTER;
                default: code = KEY_NOP;
            endcase
            2'd2: case (col)
                3'd0: code = digitCode(4'd1);
                3'd1: code = digitCode(4'd2);
                3'd2: code = digitCode(4'd3);
                3'd3: code = KEY_UP;
                3'd4: code = KEY_DOWN;
                default: code = KEY_NOP;
            endcase
            default: code = (col == 3'd0) ? digitCode(4'd0) : KEY_NOP;
        endcase
        return code;
    endfunction

    logic [4:0]         colSync;
    logic [DWELL_W-1:0] dwellCnt_q;
    logic [1:0]         rowIdx_q;
    logic [1:0]         frameHits_q;
    key_code_t          frameCode_q;
    logic               multiKey_q;
    key_state_e         state_q, state_d;
    key_code_t          cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               keyValid_q, keyValid_d;
    key_code_t          keyCode_q, keyCode_d;

    logic               sampleNow;
    logic               frameEnd;
    logic [1:0]         rowHits;
    key_code_t          rowCode;
    logic [1:0]         baseHits;
    logic [2:0]         sumHits;
    logic [1:0]         mergedHits;
    key_code_t          mergedCode;
    frame_kind_e        frameKind;
    logic [CNT_W-1:0]   cntInc;

    sync_2ff #(.WIDTH(5), .RESET_VAL(5'b11111)) uColSync (
        .clk (clk),
        .rst (rst),
        .d_i (kp.col_n),
        .q_o (colSync)
    );

    assign sampleNow = (dwellCnt_q == DWELL_LAST);
    assign frameEnd  = sampleNow && (rowIdx_q == 2'd3);

    // Row dwell timer; the row advances right after its columns are sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwellCnt_q <= '0;
            rowIdx_q   <= 2'd0;
        end else if (sampleNow) begin
            dwellCnt_q <= '0;
            rowIdx_q   <= rowIdx_q + 2'd1;
        end else begin
            dwellCnt_q <= dwellCnt_q + DWELL_W'(1);
        end
    end

    assign kp.row_n = ~(4'b0001 << rowIdx_q);

    // Count pressed columns in the current row (saturating at two) and encode the lowest one.
    always_comb begin
        rowHits = 2'd0;
        rowCode = KEY_NOP;
        for (int c = 4; c >= 0; c--) begin
            if (!colSync[c]) begin
                if (rowHits != 2'd2) rowHits = rowHits + 2'd1;
                rowCode = keyMap(rowIdx_q, 3'(c));
            end
        end
    end

    // Merge this row into the running frame result; row 0 starts a fresh frame.
    always_comb begin
        baseHits   = (rowIdx_q == 2'd0) ? 2'd0 : frameHits_q;
        sumHits    = {1'b0, baseHits} + {1'b0, rowHits};
        mergedHits = (sumHits >= 3'd2) ? 2'd2 : sumHits[1:0];
        mergedCode = (baseHits == 2'd0) ? rowCode : frameCode_q;
        case (mergedHits)
            2'd0:    frameKind = FRAME_NONE;
            2'd1:    frameKind = FRAME_SINGLE;
            default: frameKind = FRAME_MULTI;
        endcase
    end

    // Hold the partial frame result between row samples and publish multi_key at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frameHits_q <= 2'd0;
            frameCode_q <= KEY_NOP;
            multiKey_q  <= 1'b0;
        end else if (sampleNow) begin
            frameHits_q <= mergedHits;
            frameCode_q <= mergedCode;
            if (frameEnd) multiKey_q <= (mergedHits == 2'd2);
        end
    end

    // Debounce state register together with the candidate key and its counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= KEY_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cntInc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state logic: decisions are taken only on complete frames.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (frameEnd) begin
            case (state_q)
                IDLE: begin
                    if (frameKind == FRAME_SINGLE) begin
                        state_d = PRESS_WAIT;
                        cand_d  = mergedCode;
                        cnt_d   = CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (frameKind == FRAME_SINGLE) begin
                        if (mergedCode == cand_q) begin
                            cnt_d = cntInc;
                            if (cntInc >= CNT_MAX) state_d = HELD;
                        end else begin
                            cand_d = mergedCode;
                            cnt_d  = CNT_W'(1);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (frameKind == FRAME_NONE) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (frameKind == FRAME_NONE) begin
                        cnt_d = cntInc;
                        if (cntInc >= CNT_MAX) state_d = IDLE;
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode: the code latches only on the press-accept transition, alongside key_valid.
    always_comb begin
        keyValid_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        keyCode_d  = keyCode_q;
        if ((state_d == HELD) && (state_q == PRESS_WAIT)) keyCode_d = cand_q;
    end

    // Registered outputs keep key_valid and key_code glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keyValid_q <= 1'b0;
            keyCode_q  <= KEY_NOP;
        end else begin
            keyValid_q <= keyValid_d;
            keyCode_q  <= keyCode_d;
        end
    end

    assign kp.key_code  = keyCode_q;
    assign kp.key_valid = keyValid_q;
    assign kp.multi_key = multiKey_q;

endmodule
